// File: rtl/signmagnitude_to_twoscomplement_serial.sv
// Bit-serial sign-magnitude to two's complement converter, LSB first.
// A word is accepted in IDLE, converted one bit per clock in SHIFT and
// presented in DONE until the downstream side takes it.
// Optional feature macro: SM2TC_NEGZERO_FLAG_EN adds the neg_zero output,
// which flags a negative-zero input alongside the (zero) result.
module signmagnitude_to_twoscomplement_serial #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sign,
  input  logic [W-2:0] in_mag,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
`ifdef SM2TC_NEGZERO_FLAG_EN
  ,
  output logic         neg_zero
`endif
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  cnt;
  logic           seen_one;
  logic           sign_r;
  logic [W-2:0]   mag_r;
  logic [W-2:0]   acc;
  logic           last_bit;
  logic           res_bit;
  logic           accept;
  logic           release_out;

  // One output bit: copy up to and including the first 1, invert afterwards
  // when negative; the MSB is the sign only if a non-zero magnitude was seen.
  function automatic logic conv_bit(input logic s, input logic seen,
                                    input logic b, input logic msb);
    if (msb)
      return s & seen;
    return (s & seen) ? ~b : b;
  endfunction

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign accept      = in_valid && in_ready;
  assign release_out = out_valid && out_ready;
  assign last_bit    = (cnt == CW'(W - 1));
  assign res_bit     = conv_bit(sign_r, seen_one, mag_r[0], last_bit);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = SHIFT;
      SHIFT:   if (last_bit)    state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Control: bit counter, first-one tracker and the finished result word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      seen_one <= 1'b0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt      <= '0;
            seen_one <= 1'b0;
          end
        end
        SHIFT: begin
          cnt      <= cnt + CW'(1);
          seen_one <= seen_one | mag_r[0];
          if (last_bit)
            out_data <= {res_bit, acc};
        end
        default: ;
      endcase
    end
  end

  // Datapath: operand capture and serial assembly; fully overwritten per word
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_r <= in_sign;
      mag_r  <= in_mag;
    end else if (state == SHIFT) begin
      mag_r <= mag_r >> 1;
      acc   <= (acc >> 1) | ((W-1)'(res_bit) << (W - 2));
    end
  end

`ifdef SM2TC_NEGZERO_FLAG_EN
  logic nz_r;

  // Remember whether the accepted word was negative zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      nz_r <= 1'b0;
    else if (accept)
      nz_r <= in_sign && (in_mag == '0);
  end

  assign neg_zero = out_valid & nz_r;
`endif

endmodule

// File: tb/tb_signmagnitude_to_twoscomplement_serial.sv
// Self-checking bench for signmagnitude_to_twoscomplement_serial (W=8).
// Expected words are computed arithmetically and queued at the accepting
// edge, then popped when out_valid is observed.
module tb_signmagnitude_to_twoscomplement_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_sign = 1'b0;
  logic [W-2:0] in_mag = '0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef SM2TC_NEGZERO_FLAG_EN
  logic         neg_zero;
`endif

  int nerr = 0;
  int nchk = 0;
  logic [W-1:0] expq[$];
  logic         nzq[$];

  signmagnitude_to_twoscomplement_serial #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_mag    (in_mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SM2TC_NEGZERO_FLAG_EN
    ,
    .neg_zero  (neg_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic s, input logic [W-2:0] m);
    logic [W-1:0] v;
    v = {1'b0, m};
    return s ? (~v + 1'b1) : v;
  endfunction

  // One full transfer: accept, wait for the result, optional stall, release.
  task automatic xfer(input logic s, input logic [W-2:0] m, input int stall, input bit hold_valid);
    int           lat;
    logic [W-1:0] exp;
    logic         nz;
    logic [W-1:0] held;
    for (int i = 0; i < 10 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_sign   = s;
    in_mag    = m;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    expq.push_back(model(s, m));
    nzq.push_back(s && (m == '0));
    chk("in_ready_busy", in_ready, 0);
    if (hold_valid) begin
      in_sign = ~s;
      in_mag  = ~m;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < W + 4);
    in_valid = 1'b0;
    chk("latency", lat, W);
    chk("out_valid", out_valid, 1);
    exp = expq.pop_front();
    nz  = nzq.pop_front();
    chk("out_data", out_data, exp);
`ifdef SM2TC_NEGZERO_FLAG_EN
    chk("neg_zero", neg_zero, nz);
`endif
    chk("in_ready_done", in_ready, 0);
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, held);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
`ifdef SM2TC_NEGZERO_FLAG_EN
    chk("post_neg_zero", neg_zero, 0);
`endif
  endtask

  initial begin
    int seen;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef SM2TC_NEGZERO_FLAG_EN
    chk("rst_neg_zero", neg_zero, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    xfer(1'b0, 7'b0000101, 0, 1'b0);
    xfer(1'b1, 7'b0000101, 0, 1'b0);
    xfer(1'b1, 7'b0001010, 0, 1'b0);
    xfer(1'b1, 7'b1111111, 0, 1'b0);
    xfer(1'b0, 7'b1111111, 0, 1'b0);
    xfer(1'b1, 7'b0000000, 0, 1'b0);
    xfer(1'b0, 7'b0000000, 0, 1'b0);
    xfer(1'b1, 7'b0110011, 5, 1'b0);
    xfer(1'b0, 7'b0101010, 0, 1'b1);
    xfer(1'b1, 7'b1000000, 0, 1'b1);

    // Reset in the middle of SHIFT discards the word
    for (int i = 0; i < 10 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_mag   = 7'b0000101;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", seen, 0);
    xfer(1'b1, 7'b0001010, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      xfer(1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)), int'($urandom_range(0, 2)), 1'b0);
    end

    chk("queue_empty", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
